// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Holds the 2-bit direction counter type and its saturating update function.
package btb_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    if (taken) return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    else       return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/btb_way.sv
// One way of the BTB: per-set valid/tag/target/counter storage with a
// combinational IF-side lookup port and an EX-side lookup/write port.
module btb_way
  import btb_pkg::*;
#(
  parameter int SET_ADDR_LEN = 6,
  parameter int TAG_ADDR_LEN = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SET_ADDR_LEN-1:0] rd_set,
  input  logic [TAG_ADDR_LEN-1:0] rd_tag,
  output logic                    rd_hit,
  output ctr_t                    rd_ctr,
  output logic [31:0]             rd_target,
  input  logic [SET_ADDR_LEN-1:0] wr_set,
  input  logic [TAG_ADDR_LEN-1:0] wr_tag,
  output logic                    wr_valid,
  output logic                    wr_hit,
  output ctr_t                    wr_ctr_q,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic                    wr_alloc,
  input  logic                    wr_tgt_en,
  input  logic [31:0]             wr_target,
  input  ctr_t                    wr_ctr
);

  localparam int SETS = 1 << SET_ADDR_LEN;

  logic [SETS-1:0]         valid;
  ctr_t                    ctr    [SETS];
  logic [TAG_ADDR_LEN-1:0] tag    [SETS];
  logic [31:0]             target [SETS];

  assign rd_hit    = valid[rd_set] && (tag[rd_set] == rd_tag);
  assign rd_ctr    = ctr[rd_set];
  assign rd_target = target[rd_set];

  assign wr_valid  = valid[wr_set];
  assign wr_hit    = valid[wr_set] && (tag[wr_set] == wr_tag);
  assign wr_ctr_q  = ctr[wr_set];

  // Flush clears validity only; counters keep their history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      for (int i = 0; i < SETS; i++) ctr[i] <= CTR_WNT;
    end else if (flush) begin
      valid <= '0;
    end else if (wr_en) begin
      ctr[wr_set] <= wr_ctr;
      if (wr_alloc) valid[wr_set] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      if (wr_alloc)  tag[wr_set]    <= wr_tag;
      if (wr_tgt_en) target[wr_set] <= wr_target;
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB top: combinational next-PC prediction, EX-side update
// with hit-first allocation, lowest-invalid/round-robin victim choice, flush.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int   SET_ADDR_LEN = 6,
  parameter int   WAYS         = 2,
  parameter int   TAG_ADDR_LEN = 24,
  parameter ctr_t CTR_INIT     = CTR_WT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] rd_pc,
  output logic [31:0] pred_pc,
  output logic        pred_take,
  output logic        pred_hit,
  input  logic        wr_en,
  input  logic        is_branch,
  input  logic [31:0] wr_pc,
  input  logic [31:0] wr_target,
  input  logic        taken,
  input  logic        flush
);

  localparam int SETS   = 1 << SET_ADDR_LEN;
  localparam int PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_LO = SET_ADDR_LEN + 2;
  localparam logic [31:0] USED_MASK = ((32'h1 << (TAG_ADDR_LEN + SET_ADDR_LEN)) - 32'h1) << 2;

  logic [SET_ADDR_LEN-1:0] rd_set, wr_set;
  logic [TAG_ADDR_LEN-1:0] rd_tag, wr_tag;

  assign rd_set = rd_pc[SET_ADDR_LEN+1:2];
  assign rd_tag = rd_pc[TAG_ADDR_LEN+TAG_LO-1:TAG_LO];
  assign wr_set = wr_pc[SET_ADDR_LEN+1:2];
  assign wr_tag = wr_pc[TAG_ADDR_LEN+TAG_LO-1:TAG_LO];

  logic unused_wr_bits;
  assign unused_wr_bits = ^(wr_pc & ~USED_MASK);

  logic [WAYS-1:0]        rd_hit, lk_valid, lk_hit, way_we;
  logic [WAYS-1:0][31:0]  rd_target;
  ctr_t                   rd_ctr [WAYS];
  ctr_t                   lk_ctr [WAYS];
  logic                   wr_alloc, wr_tgt_en, ptr_adv;
  ctr_t                   wr_ctr;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    btb_way #(
      .SET_ADDR_LEN (SET_ADDR_LEN),
      .TAG_ADDR_LEN (TAG_ADDR_LEN)
    ) u_way (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_set    (rd_set),
      .rd_tag    (rd_tag),
      .rd_hit    (rd_hit[w]),
      .rd_ctr    (rd_ctr[w]),
      .rd_target (rd_target[w]),
      .wr_set    (wr_set),
      .wr_tag    (wr_tag),
      .wr_valid  (lk_valid[w]),
      .wr_hit    (lk_hit[w]),
      .wr_ctr_q  (lk_ctr[w]),
      .flush     (flush),
      .wr_en     (way_we[w]),
      .wr_alloc  (wr_alloc),
      .wr_tgt_en (wr_tgt_en),
      .wr_target (wr_target),
      .wr_ctr    (wr_ctr)
    );
  end

  logic [31:0] hit_target;

  always_comb begin
    pred_hit   = 1'b0;
    pred_take  = 1'b0;
    hit_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (rd_hit[w]) begin
        pred_hit   = 1'b1;
        pred_take  = rd_ctr[w][1];
        hit_target = rd_target[w];
      end
    end
    pred_pc = pred_take ? hit_target : rd_pc + 32'd4;
  end

  logic [PTR_W-1:0] cur_ptr, inv_idx, victim;
  logic             found_inv, wr_any_hit, upd;
  ctr_t             hit_ctr;

  assign upd = wr_en && is_branch && !flush;

  always_comb begin
    wr_any_hit = 1'b0;
    hit_ctr    = CTR_SNT;
    found_inv  = 1'b0;
    inv_idx    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (lk_hit[w]) begin
        wr_any_hit = 1'b1;
        hit_ctr    = lk_ctr[w];
      end
    end
    // Downward scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!lk_valid[w]) begin
        found_inv = 1'b1;
        inv_idx   = PTR_W'(w);
      end
    end
    victim = found_inv ? inv_idx : cur_ptr;
  end

  always_comb begin
    way_we    = '0;
    wr_alloc  = 1'b0;
    wr_tgt_en = 1'b0;
    wr_ctr    = hit_ctr;
    ptr_adv   = 1'b0;
    if (upd) begin
      if (wr_any_hit) begin
        way_we    = lk_hit;
        wr_tgt_en = taken;
        wr_ctr    = ctr_next(hit_ctr, taken);
      end else if (taken) begin
        way_we[victim] = 1'b1;
        wr_alloc       = 1'b1;
        wr_tgt_en      = 1'b1;
        wr_ctr         = CTR_INIT;
        ptr_adv        = !found_inv;
      end
    end
  end

  if (WAYS > 1) begin : g_ptr
    logic [PTR_W-1:0] vptr [SETS];

    assign cur_ptr = vptr[wr_set];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < SETS; i++) vptr[i] <= '0;
      end else if (flush) begin
        for (int i = 0; i < SETS; i++) vptr[i] <= '0;
      end else if (ptr_adv) begin
        vptr[wr_set] <= (vptr[wr_set] == PTR_W'(WAYS - 1)) ? '0 : vptr[wr_set] + PTR_W'(1);
      end
    end
  end else begin : g_noptr
    assign cur_ptr = '0;
  end

endmodule

// File: tb/tb_btb_assoc.sv
// Bench for btb_assoc: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against an array-based reference model.
module tb_btb_assoc;

  localparam int SETS = 64;
  localparam int WAYS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rd_pc, pred_pc, wr_pc, wr_target;
  logic        pred_take, pred_hit, wr_en, is_branch, taken, flush;

  always #5 clk = ~clk;

  btb_assoc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_pc     (rd_pc),
    .pred_pc   (pred_pc),
    .pred_take (pred_take),
    .pred_hit  (pred_hit),
    .wr_en     (wr_en),
    .is_branch (is_branch),
    .wr_pc     (wr_pc),
    .wr_target (wr_target),
    .taken     (taken),
    .flush     (flush)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic eh, input logic et, input logic [31:0] ep);
    total++;
    if (pred_hit !== eh || pred_take !== et || pred_pc !== ep) begin
      bad++;
      $display("FAIL %s: got hit=%0b take=%0b pc=%h, expected hit=%0b take=%0b pc=%h",
               name, pred_hit, pred_take, pred_pc, eh, et, ep);
    end
  endtask

  // Reference model: plain per-set arrays of entries plus a round-robin index.
  bit          mv   [SETS][WAYS];
  int unsigned mtag [SETS][WAYS];
  logic [31:0] mtgt [SETS][WAYS];
  int          mctr [SETS][WAYS];
  int          mptr [SETS];

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      mptr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin
        mv[s][w] = 0;
        mctr[s][w] = 1;
      end
    end
  endfunction

  function automatic void model_predict(input logic [31:0] pc, output logic h, output logic t,
                                        output logic [31:0] np);
    int unsigned s  = (pc >> 2) % SETS;
    int unsigned tg = pc >> 8;
    h = 0; t = 0; np = pc + 32'd4;
    for (int w = 0; w < WAYS; w++) begin
      if (mv[s][w] && mtag[s][w] == tg) begin
        h = 1;
        if (mctr[s][w] >= 2) begin
          t = 1;
          np = mtgt[s][w];
        end
      end
    end
  endfunction

  function automatic void model_update(input bit we, input bit br, input logic [31:0] pc,
                                       input logic [31:0] tgt, input bit tk, input bit fl);
    int unsigned s  = (pc >> 2) % SETS;
    int unsigned tg = pc >> 8;
    int hw = -1;
    int v  = -1;
    if (fl) begin
      for (int i = 0; i < SETS; i++) begin
        mptr[i] = 0;
        for (int w = 0; w < WAYS; w++) mv[i][w] = 0;
      end
      return;
    end
    if (!(we && br)) return;
    for (int w = 0; w < WAYS; w++) if (mv[s][w] && mtag[s][w] == tg) hw = w;
    if (hw >= 0) begin
      if (tk) begin
        mctr[s][hw] = (mctr[s][hw] < 3) ? mctr[s][hw] + 1 : 3;
        mtgt[s][hw] = tgt;
      end else begin
        mctr[s][hw] = (mctr[s][hw] > 0) ? mctr[s][hw] - 1 : 0;
      end
    end else if (tk) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!mv[s][w]) v = w;
      if (v < 0) begin
        v = mptr[s];
        mptr[s] = (mptr[s] + 1) % WAYS;
      end
      mv[s][v] = 1; mtag[s][v] = tg; mtgt[s][v] = tgt; mctr[s][v] = 2;
    end
  endfunction

  typedef struct {
    bit          we;
    bit          br;
    logic [31:0] wpc;
    logic [31:0] wt;
    bit          tk;
    bit          fl;
    logic [31:0] rpc;
    bit          eh;
    bit          et;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit we, input bit br, input logic [31:0] wpc, input logic [31:0] wt,
                              input bit tk, input bit fl, input logic [31:0] rpc,
                              input bit eh, input bit et, input logic [31:0] ep);
    vec_t v;
    v.we = we; v.br = br; v.wpc = wpc; v.wt = wt; v.tk = tk; v.fl = fl;
    v.rpc = rpc; v.eh = eh; v.et = et; v.ep = ep;
    vecs.push_back(v);
  endfunction

  initial begin
    logic        eh, et;
    logic [31:0] ep;

    //  we br wpc       wt        tk fl rpc          hit take pc
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h100,     0, 0, 32'h104);
    add(1, 1, 32'h100, 32'h200,  1, 0, 32'h100,     1, 1, 32'h200);
    add(1, 1, 32'h100, 32'h200,  0, 0, 32'h100,     1, 0, 32'h104);
    add(1, 1, 32'h100, 32'h200,  1, 0, 32'h100,     1, 1, 32'h200);
    add(1, 1, 32'h100, 32'h200,  1, 0, 32'h100,     1, 1, 32'h200);
    add(1, 1, 32'h100, 32'h200,  1, 0, 32'h100,     1, 1, 32'h200);
    add(1, 1, 32'h100, 32'h200,  0, 0, 32'h100,     1, 1, 32'h200);
    add(1, 1, 32'h100, 32'h280,  1, 0, 32'h100,     1, 1, 32'h280);
    add(1, 1, 32'h100, 32'h999,  0, 0, 32'h100,     1, 1, 32'h280);
    add(1, 1, 32'h200, 32'h1000, 1, 0, 32'h200,     1, 1, 32'h1000);
    add(1, 1, 32'h300, 32'h2000, 1, 0, 32'h300,     1, 1, 32'h2000);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h100,     0, 0, 32'h104);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h200,     1, 1, 32'h1000);
    add(1, 1, 32'h500, 32'h3000, 1, 0, 32'h300,     1, 1, 32'h2000);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h200,     0, 0, 32'h204);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h500,     1, 1, 32'h3000);
    add(1, 1, 32'h600, 32'h60,   0, 0, 32'h600,     0, 0, 32'h604);
    add(1, 0, 32'h900, 32'h10,   1, 0, 32'h900,     0, 0, 32'h904);
    add(1, 1, 32'h104, 32'h40,   1, 0, 32'h104,     1, 1, 32'h40);
    add(1, 1, 32'h104, 32'h40,   0, 0, 32'h104,     1, 0, 32'h108);
    add(1, 1, 32'h104, 32'h40,   0, 0, 32'h104,     1, 0, 32'h108);
    add(1, 1, 32'h104, 32'h40,   0, 0, 32'h104,     1, 0, 32'h108);
    add(1, 1, 32'h104, 32'h40,   1, 0, 32'h104,     1, 0, 32'h108);
    add(1, 1, 32'h104, 32'h40,   1, 0, 32'h104,     1, 1, 32'h40);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'hFFFFFFFC, 0, 0, 32'h0);
    add(1, 1, 32'h700, 32'h50,   1, 1, 32'h300,     0, 0, 32'h304);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h700,     0, 0, 32'h704);
    add(0, 0, 32'h0,   32'h0,    0, 0, 32'h104,     0, 0, 32'h108);
    add(1, 1, 32'h700, 32'h50,   1, 0, 32'h700,     1, 1, 32'h50);

    rst_n = 1'b0;
    rd_pc = '0; wr_pc = '0; wr_target = '0;
    wr_en = 1'b0; is_branch = 1'b0; taken = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; is_branch = vecs[i].br; wr_pc = vecs[i].wpc;
      wr_target = vecs[i].wt; taken = vecs[i].tk; flush = vecs[i].fl;
      rd_pc = vecs[i].rpc;
      @(posedge clk);
      @(negedge clk);
      wr_en = 1'b0; flush = 1'b0;
      rd_pc = vecs[i].rpc;
      #1 check($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].ep);
    end

    // Same-cycle read and allocate: old contents until the edge.
    @(negedge clk);
    rd_pc = 32'h400; wr_pc = 32'h400; wr_target = 32'h4400;
    wr_en = 1'b1; is_branch = 1'b1; taken = 1'b1;
    #1 check("rw_same_pre", 1'b0, 1'b0, 32'h404);
    @(posedge clk);
    #1 check("rw_same_post", 1'b1, 1'b1, 32'h4400);

    // Asynchronous reset in the middle of an allocation.
    @(negedge clk);
    wr_pc = 32'h900; wr_target = 32'h99; rd_pc = 32'h400;
    #1 check("pre_async_rst", 1'b1, 1'b1, 32'h4400);
    rst_n = 1'b0;
    #1 check("during_rst", 1'b0, 1'b0, 32'h404);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    rd_pc = 32'h900;
    #1 check("rst_no_partial", 1'b0, 1'b0, 32'h904);
    rd_pc = 32'h400;
    #1 check("rst_cleared", 1'b0, 1'b0, 32'h404);

    // Randomized traffic on a small PC pool to force conflicts and evictions.
    model_reset();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      wr_pc     = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      rd_pc     = ($urandom_range(0, 3) == 0) ? wr_pc
                : (($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      wr_target = $urandom;
      wr_en     = ($urandom_range(0, 3) != 0);
      is_branch = ($urandom_range(0, 7) != 0);
      taken     = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      #1;
      model_predict(rd_pc, eh, et, ep);
      check($sformatf("rand%0d", n), eh, et, ep);
      @(posedge clk);
      model_update(wr_en, is_branch, wr_pc, wr_target, taken, flush);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
